// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: writeback request, register-file write and bypass signals of regfile_wb_queue.
// Carries stall_cnt only when WBQ_STALL_CNT_EN is defined.
interface regfile_wb_queue_if #(parameter int AW = 2);
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_overflow;
  logic        alu_of_control;
  logic        alu_ready;
  logic        wr_stall;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic        overflow_flag;
  logic        of_control;
  logic [4:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [AW:0] count;
`ifdef WBQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, alu_overflow, alu_of_control,
    input  wr_stall, fwd_reg,
    output mem_ready, alu_ready, regwrite, wrreg, wrdata, overflow_flag, of_control, fwd_hit, fwd_data,
    output count, stall_cnt
  );
  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, alu_overflow, alu_of_control,
    output wr_stall, fwd_reg,
    input  mem_ready, alu_ready, regwrite, wrreg, wrdata, overflow_flag, of_control, fwd_hit, fwd_data,
    input  count, stall_cnt
  );
`else
  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, alu_overflow, alu_of_control,
    input  wr_stall, fwd_reg,
    output mem_ready, alu_ready, regwrite, wrreg, wrdata, overflow_flag, of_control, fwd_hit, fwd_data,
    output count
  );
  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, alu_overflow, alu_of_control,
    output wr_stall, fwd_reg,
    input  mem_ready, alu_ready, regwrite, wrreg, wrdata, overflow_flag, of_control, fwd_hit, fwd_data,
    input  count
  );
`endif
endinterface

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback queue feeding the register file write port, with bypass lookup.
// Optional WBQ_STALL_CNT_EN adds a saturating counter of stalled non-empty cycles.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic clk,
  input logic rst,
  regfile_wb_queue_if.slave bus
);
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ov;
    logic        ofc;
  } entry_t;
  entry_t      q_q [DEPTH];
  entry_t      head;
  entry_t      e;
  logic [AW-1:0] rp_q, wp_q;
  logic [AW:0]   count_q, count_d;
  logic          mem_push, alu_push, pop;
  logic          regwrite_q, ovf_q, ofc_q;
  logic [4:0]    wrreg_q;
  logic [31:0]   wrdata_q;
  logic          fwd_hit_d;
  logic [31:0]   fwd_data_d;
  assign bus.mem_ready = count_q < (AW+1)'(DEPTH);
  assign bus.alu_ready = count_q + (AW+1)'(bus.mem_valid) < (AW+1)'(DEPTH);
  // reg 0 writes are dropped unless they carry an overflow check that must reach the register file
  assign mem_push = bus.mem_valid && bus.mem_ready && bus.mem_reg != 5'd0;
  assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_reg != 5'd0 || bus.alu_of_control);
  assign pop      = count_q != '0 && !bus.wr_stall;
  assign head     = q_q[rp_q];
  assign count_d  = count_q + (AW+1)'(mem_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
  always_ff @(posedge clk) begin
    if (mem_push) q_q[wp_q] <= {bus.mem_reg, bus.mem_data, 1'b0, 1'b0};
    if (alu_push) q_q[wp_q + AW'(mem_push)] <= {bus.alu_reg, bus.alu_data, bus.alu_overflow, bus.alu_of_control};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(mem_push) + AW'(alu_push);
      rp_q    <= rp_q + AW'(pop);
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      ovf_q      <= 1'b0;
      ofc_q      <= 1'b0;
      wrreg_q    <= '0;
      wrdata_q   <= '0;
    end else if (pop) begin
      regwrite_q <= !(head.ov && head.ofc);
      ovf_q      <= head.ov;
      ofc_q      <= head.ofc;
      wrreg_q    <= head.rd;
      wrdata_q   <= head.data;
    end else begin
      regwrite_q <= 1'b0;
      ovf_q      <= 1'b0;
      ofc_q      <= 1'b0;
    end
  end
  // walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    e          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = q_q[rp_q + AW'(i)];
      if ((AW+1)'(i) < count_q && bus.fwd_reg != 5'd0 && e.rd == bus.fwd_reg && !(e.ov && e.ofc)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = e.data;
      end
    end
  end
  assign bus.fwd_hit       = fwd_hit_d;
  assign bus.fwd_data      = fwd_data_d;
  assign bus.regwrite      = regwrite_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.of_control    = ofc_q;
  assign bus.wrreg         = wrreg_q;
  assign bus.wrdata        = wrdata_q;
  assign bus.count         = count_q;
`ifdef WBQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else if (count_q != '0 && bus.wr_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
